// File: rtl/vga_axil_pkg.sv
// Shared widths, types and helpers for the VGA AXI4-Lite register slave.
// Both the bus interface and the protocol engine import this package.
package vga_axil_pkg;

  localparam int AXIL_ADDR_WIDTH   = 32;
  localparam int AXIL_DATA_WIDTH   = 32;
  localparam int AXIL_WIDTH_OFFSET = 2;
  localparam int NATIVE_ADDR_WIDTH = AXIL_ADDR_WIDTH - AXIL_WIDTH_OFFSET;

  typedef logic [AXIL_ADDR_WIDTH-1:0]   axil_addr_t;
  typedef logic [AXIL_DATA_WIDTH-1:0]   axil_data_t;
  typedef logic [AXIL_DATA_WIDTH/8-1:0] axil_strb_t;
  typedef logic [NATIVE_ADDR_WIDTH-1:0] native_addr_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  typedef enum logic [2:0] {
    W_IDLE      = 3'd0,
    W_WAIT_DATA = 3'd1,
    W_WAIT_ADDR = 3'd2,
    W_WRITE     = 3'd3,
    W_RESP      = 3'd4
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_READ = 2'd1,
    R_WAIT = 2'd2,
    R_RESP = 2'd3
  } r_state_e;

  // Byte address to word address; the byte offset is simply dropped.
  function automatic native_addr_t axil2native_addr(input axil_addr_t addr);
    native_addr_t                 word;
    logic [AXIL_WIDTH_OFFSET-1:0] unused_byte_ofs;
    {word, unused_byte_ofs} = addr;
    return word;
  endfunction

endpackage

// File: rtl/axil_slave_fsm_if.sv
// AXI4-Lite channel bundle between a bus master and the VGA register slave.
interface axil_slave_fsm_if;
  import vga_axil_pkg::*;

  axil_addr_t awaddr;
  logic       awvalid;
  logic       awready;
  axil_data_t wdata;
  axil_strb_t wstrb;
  logic       wvalid;
  logic       wready;
  logic [1:0] bresp;
  logic       bvalid;
  logic       bready;
  axil_addr_t araddr;
  logic       arvalid;
  logic       arready;
  axil_data_t rdata;
  logic [1:0] rresp;
  logic       rvalid;
  logic       rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_slave_fsm.sv
// AXI4-Lite slave for the VGA register space: independent write and read
// FSMs that turn bus transactions into single-cycle native strobes.
module axil_slave_fsm
  import vga_axil_pkg::*;
(
  input  logic            clk,
  input  logic            arst_n,
  axil_slave_fsm_if.slave bus,
  output logic            write_en,
  output native_addr_t    addr_write,
  output axil_data_t      data2native,
  output logic            read_en_sync,
  output native_addr_t    addr_read,
  input  axil_data_t      data2axil
);

  w_state_e     w_state_r, w_state_s;
  r_state_e     r_state_r, r_state_s;
  logic         awready_r, wready_r, bvalid_r, write_en_r;
  logic         arready_r, rvalid_r, read_en_r;
  native_addr_t addr_write_r, addr_read_r;
  axil_data_t   data2native_r, rdata_r;
  logic         aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic         unused_wstrb_s;

  assign aw_hs_s        = bus.awvalid & awready_r;
  assign w_hs_s         = bus.wvalid & wready_r;
  assign b_hs_s         = bvalid_r & bus.bready;
  assign ar_hs_s        = bus.arvalid & arready_r;
  assign r_hs_s         = rvalid_r & bus.rready;
  assign unused_wstrb_s = ^bus.wstrb;

  // Write next-state: AW and W may complete together or in either order.
  always_comb begin
    w_state_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) w_state_s = W_WRITE;
        else if (aw_hs_s)      w_state_s = W_WAIT_DATA;
        else if (w_hs_s)       w_state_s = W_WAIT_ADDR;
        else                   w_state_s = W_IDLE;
      end
      W_WAIT_DATA: if (w_hs_s)  w_state_s = W_WRITE; else w_state_s = W_WAIT_DATA;
      W_WAIT_ADDR: if (aw_hs_s) w_state_s = W_WRITE; else w_state_s = W_WAIT_ADDR;
      W_WRITE:                  w_state_s = W_RESP;
      W_RESP:      if (b_hs_s)  w_state_s = W_IDLE;  else w_state_s = W_RESP;
      default:                  w_state_s = W_IDLE;
    endcase
  end

  // Write state, registered handshake outputs and captured address/data.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      w_state_r     <= W_IDLE;
      awready_r     <= 1'b0;
      wready_r      <= 1'b0;
      write_en_r    <= 1'b0;
      bvalid_r      <= 1'b0;
      addr_write_r  <= '0;
      data2native_r <= '0;
    end else begin
      w_state_r  <= w_state_s;
      awready_r  <= (w_state_s == W_IDLE) || (w_state_s == W_WAIT_ADDR);
      wready_r   <= (w_state_s == W_IDLE) || (w_state_s == W_WAIT_DATA);
      write_en_r <= (w_state_s == W_WRITE);
      bvalid_r   <= (w_state_s == W_RESP);
      if (aw_hs_s) addr_write_r  <= axil2native_addr(bus.awaddr);
      if (w_hs_s)  data2native_r <= bus.wdata;
    end
  end

  // Read next-state: strobe, wait one cycle for native data, then respond.
  always_comb begin
    r_state_s = r_state_r;
    case (r_state_r)
      R_IDLE:  if (ar_hs_s) r_state_s = R_READ; else r_state_s = R_IDLE;
      R_READ:               r_state_s = R_WAIT;
      R_WAIT:               r_state_s = R_RESP;
      R_RESP:  if (r_hs_s)  r_state_s = R_IDLE; else r_state_s = R_RESP;
      default:              r_state_s = R_IDLE;
    endcase
  end

  // Read state, registered outputs; rdata is loaded only when leaving R_WAIT.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state_r   <= R_IDLE;
      arready_r   <= 1'b0;
      read_en_r   <= 1'b0;
      rvalid_r    <= 1'b0;
      addr_read_r <= '0;
      rdata_r     <= '0;
    end else begin
      r_state_r <= r_state_s;
      arready_r <= (r_state_s == R_IDLE);
      read_en_r <= (r_state_s == R_READ);
      rvalid_r  <= (r_state_s == R_RESP);
      if (ar_hs_s)              addr_read_r <= axil2native_addr(bus.araddr);
      if (r_state_r == R_WAIT)  rdata_r     <= data2axil;
    end
  end

  assign bus.awready  = awready_r;
  assign bus.wready   = wready_r;
  assign bus.bvalid   = bvalid_r;
  assign bus.bresp    = OKAY;
  assign bus.arready  = arready_r;
  assign bus.rvalid   = rvalid_r;
  assign bus.rdata    = rdata_r;
  assign bus.rresp    = OKAY;
  assign write_en     = write_en_r;
  assign addr_write   = addr_write_r;
  assign data2native  = data2native_r;
  assign read_en_sync = read_en_r;
  assign addr_read    = addr_read_r;

endmodule

// File: tb/tb_axil_slave_fsm.sv
// Directed bench for axil_slave_fsm with a small native memory model behind
// the strobes; expected values are computed by hand in the stimulus.
module tb_axil_slave_fsm;
  import vga_axil_pkg::*;

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic         write_en, read_en_sync;
  native_addr_t addr_write, addr_read;
  axil_data_t   data2native, data2axil;

  int n_cmp = 0;
  int n_mis = 0;
  int we_cnt = 0;
  int re_cnt = 0;

  logic [31:0] last_we, last_wa, last_wd, last_re, last_ra;
  int          last_blat, last_rlat;

  axil_slave_fsm_if bus ();

  axil_slave_fsm dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .bus          (bus),
    .write_en     (write_en),
    .addr_write   (addr_write),
    .data2native  (data2native),
    .read_en_sync (read_en_sync),
    .addr_read    (addr_read),
    .data2axil    (data2axil)
  );

  always #5 clk = ~clk;

  // Native register file: write on write_en, data one cycle after read_en_sync.
  axil_data_t mem [0:1023];
  always @(posedge clk) begin
    if (write_en === 1'b1)     mem[addr_write[9:0]] <= data2native;
    if (read_en_sync === 1'b1) data2axil <= mem[addr_read[9:0]];
    if (write_en === 1'b1)     we_cnt <= we_cnt + 1;
    if (read_en_sync === 1'b1) re_cnt <= re_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_hs(input axil_addr_t a, input axil_data_t d, input int aw_dly, input int w_dly);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = 4'hF;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      @(posedge clk);
      aw_done = aw_done || aw_fire;
      w_done  = w_done || w_fire;
      cyc++;
    end
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("aw_w_handshake", {30'd0, aw_done, w_done}, 32'd3);
    last_we = {31'd0, write_en};
    last_wa = 32'(addr_write);
    last_wd = data2native;
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    last_blat = n;
    chk("bvalid", {31'd0, bus.bvalid}, 32'd1);
    chk("bresp", {30'd0, bus.bresp}, 32'd0);
    @(negedge clk);
  endtask

  task automatic axi_write(input axil_addr_t a, input axil_data_t d, input int aw_dly, input int w_dly);
    write_hs(a, d, aw_dly, w_dly);
    wait_b();
  endtask

  task automatic read_hs(input axil_addr_t a, input int dly);
    bit done, fire;
    int cyc;
    done = 1'b0; cyc = 0;
    bus.araddr = a;
    while (!done && cyc < 40) begin
      @(negedge clk);
      bus.arvalid = (cyc >= dly);
      fire = bus.arvalid && bus.arready;
      @(posedge clk);
      done = fire;
      cyc++;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("ar_handshake", {31'd0, done}, 32'd1);
    last_re = {31'd0, read_en_sync};
    last_ra = 32'(addr_read);
  endtask

  task automatic wait_r(output axil_data_t d);
    int n;
    n = 0;
    while (bus.rvalid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    last_rlat = n;
    chk("rvalid", {31'd0, bus.rvalid}, 32'd1);
    chk("rresp", {30'd0, bus.rresp}, 32'd0);
    d = bus.rdata;
    @(negedge clk);
  endtask

  task automatic axi_read(input axil_addr_t a, input int dly, output axil_data_t d);
    read_hs(a, dly);
    wait_r(d);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, {31'd0, bus.awready}, 32'd0);
    chk({tag, "_wready"},  {31'd0, bus.wready},  32'd0);
    chk({tag, "_arready"}, {31'd0, bus.arready}, 32'd0);
    chk({tag, "_bvalid"},  {31'd0, bus.bvalid},  32'd0);
    chk({tag, "_rvalid"},  {31'd0, bus.rvalid},  32'd0);
    chk({tag, "_we"},      {31'd0, write_en},     32'd0);
    chk({tag, "_re"},      {31'd0, read_en_sync}, 32'd0);
    chk({tag, "_rdata"},   bus.rdata,             32'd0);
    chk({tag, "_waddr"},   32'(addr_write),       32'd0);
  endtask

  initial begin
    axil_data_t rd;
    axil_data_t exp_d [0:4];
    axil_data_t pr_d  [0:3];
    int w0, r0, idx;

    bus.awaddr = 32'd0; bus.awvalid = 1'b0; bus.wdata = 32'd0; bus.wstrb = 4'h0;
    bus.wvalid = 1'b0; bus.bready = 1'b1; bus.araddr = 32'd0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;

    // Reset state, then ready after release.
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    chk("rst_bresp", {30'd0, bus.bresp}, 32'd0);
    chk("rst_rresp", {30'd0, bus.rresp}, 32'd0);
    arst_n = 1'b1;
    @(negedge clk);
    chk("idle_awready", {31'd0, bus.awready}, 32'd1);
    chk("idle_wready",  {31'd0, bus.wready},  32'd1);
    chk("idle_arready", {31'd0, bus.arready}, 32'd1);

    // Sequential writes then reads of 0x0..0x24.
    w0 = we_cnt; r0 = re_cnt;
    for (int i = 0; i < 10; i++) begin
      axi_write(32'(i * 4), 32'(i * 4), 0, 0);
      chk("seq_we", last_we, 32'd1);
      chk("seq_waddr", last_wa, 32'(i));
      chk("seq_wdata", last_wd, 32'(i * 4));
      chk("seq_blat", 32'(last_blat), 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      axi_read(32'(i * 4), 0, rd);
      chk("seq_re", last_re, 32'd1);
      chk("seq_raddr", last_ra, 32'(i));
      chk("seq_rlat", 32'(last_rlat), 32'd2);
      chk("seq_rdata", rd, 32'(i * 4));
    end
    chk("seq_we_count", 32'(we_cnt - w0), 32'd10);
    chk("seq_re_count", 32'(re_cnt - r0), 32'd10);

    // Unaligned addresses map to the containing word.
    axi_write(32'h0000_002B, 32'hDEAD_BEEF, 0, 0);
    chk("unal_waddr", last_wa, 32'h0000_000A);
    axi_read(32'h0000_0029, 0, rd);
    chk("unal_raddr", last_ra, 32'h0000_000A);
    chk("unal_rdata", rd, 32'hDEAD_BEEF);

    // AW three cycles ahead of W, then W three cycles ahead of AW.
    w0 = we_cnt;
    axi_write(32'h0000_0040, 32'h1111_2222, 0, 3);
    chk("aw_first_we", last_we, 32'd1);
    chk("aw_first_blat", 32'(last_blat), 32'd1);
    axi_write(32'h0000_0044, 32'h3333_4444, 3, 0);
    chk("w_first_we", last_we, 32'd1);
    chk("w_first_waddr", last_wa, 32'h0000_0011);
    chk("order_we_count", 32'(we_cnt - w0), 32'd2);
    axi_read(32'h0000_0040, 0, rd);
    chk("aw_first_rdata", rd, 32'h1111_2222);
    axi_read(32'h0000_0044, 0, rd);
    chk("w_first_rdata", rd, 32'h3333_4444);

    // Concurrent write to one address while reading a preloaded one.
    axi_write(32'h0000_0080, 32'hCAFE_F00D, 0, 0);
    fork
      axi_write(32'h0000_0084, 32'h5A5A_5A5A, 0, 0);
      axi_read(32'h0000_0080, 0, rd);
    join
    chk("conc_rdata", rd, 32'hCAFE_F00D);
    axi_read(32'h0000_0084, 0, rd);
    chk("conc_wdata", rd, 32'h5A5A_5A5A);

    // Random idle gaps; five addresses each written twice.
    w0 = we_cnt; r0 = re_cnt;
    for (int k = 0; k < 10; k++) begin
      exp_d[k % 5] = $urandom;
      repeat ($urandom_range(0, 10)) @(negedge clk);
      axi_write(32'h0000_0100 + 32'((k % 5) * 4), exp_d[k % 5],
                int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
    end
    for (int k = 0; k < 10; k++) begin
      idx = int'($urandom_range(0, 4));
      repeat ($urandom_range(0, 10)) @(negedge clk);
      axi_read(32'h0000_0100 + 32'(idx * 4), int'($urandom_range(0, 10)), rd);
      chk("rnd_rdata", rd, exp_d[idx]);
    end
    chk("rnd_we_count", 32'(we_cnt - w0), 32'd10);
    chk("rnd_re_count", 32'(re_cnt - r0), 32'd10);

    // Backpressure on both response channels for five cycles.
    bus.bready = 1'b0; bus.rready = 1'b0;
    write_hs(32'h0000_0200, 32'h0000_0077, 0, 0);
    read_hs(32'h0000_0100, 0);
    repeat (3) @(negedge clk);
    bus.awaddr = 32'h0000_0300; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 32'h0000_0104; bus.arvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_bvalid",  {31'd0, bus.bvalid},  32'd1);
      chk("bp_rvalid",  {31'd0, bus.rvalid},  32'd1);
      chk("bp_rdata",   bus.rdata,            exp_d[0]);
      chk("bp_awready", {31'd0, bus.awready}, 32'd0);
      chk("bp_arready", {31'd0, bus.arready}, 32'd0);
      @(negedge clk);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    chk("bp_bvalid_done",  {31'd0, bus.bvalid},  32'd0);
    chk("bp_rvalid_done",  {31'd0, bus.rvalid},  32'd0);
    chk("bp_awready_back", {31'd0, bus.awready}, 32'd1);
    chk("bp_arready_back", {31'd0, bus.arready}, 32'd1);
    axi_read(32'h0000_0200, 0, rd);
    chk("bp_wdata", rd, 32'h0000_0077);

    // Asynchronous reset in the middle of random traffic.
    fork
      begin
        for (int c = 0; c < 150; c++) begin
          @(negedge clk);
          bus.awvalid = 1'($urandom_range(0, 1));
          bus.wvalid  = 1'($urandom_range(0, 1));
          bus.arvalid = 1'($urandom_range(0, 1));
          bus.bready  = 1'($urandom_range(0, 1));
          bus.rready  = 1'($urandom_range(0, 1));
          bus.awaddr  = 32'($urandom_range(0, 255)) << 2;
          bus.araddr  = 32'($urandom_range(0, 255)) << 2;
          bus.wdata   = $urandom;
        end
      end
      begin
        #($urandom_range(500, 1000));
        arst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        #($urandom_range(50, 100));
        @(negedge clk);
        arst_n = 1'b1;
      end
    join
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_awready", {31'd0, bus.awready}, 32'd1);
    chk("post_rst_arready", {31'd0, bus.arready}, 32'd1);
    chk("post_rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
    chk("post_rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
    for (int k = 0; k < 4; k++) begin
      pr_d[k] = $urandom;
      axi_write(32'h0000_0400 + 32'(k * 4), pr_d[k], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 4; k++) begin
      axi_read(32'h0000_0400 + 32'(k * 4), int'($urandom_range(0, 3)), rd);
      chk("post_rst_rdata", rd, pr_d[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
